complete_arbiter: RTL and testbench

- Complete stage of the out-of-order pipe; replaces the stubbed completion signals at the CPU top.
- Collects finished instructions from two execution sources: the ALU pipe and the load/store pipe (store queue isLS output).
- Buffers each source in a small FIFO and grants one completion per cycle, round-robin.
- Drives the registered completion bus read by the ROB, map table, ls_station and the physical register write port.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cmpl_fifo.sv | 52 +++++
 rtl/complete_arbiter.sv | 115 +++++++++++
 tb/tb_complete_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: ROB/physical-register widths and the completion entry
// carried from the execution pipes through the complete stage.
package cpu_pkg;
  localparam int ROB_W  = 4;
  localparam int PR_W   = 6;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [PR_W-1:0]   p_rd;
    logic              RegDest;
    logic [DATA_W-1:0] result;
    logic              changeFlow;
    logic [DATA_W-1:0] jb_addr;
  } cmpl_entry_t;
endpackage

// File: rtl/cmpl_fifo.sv
// Per-source completion FIFO. Recovery clears the valid bit of every stored
// entry whose ROB number matches; the slot is reclaimed when it reaches the head.
module cmpl_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  cmpl_entry_t               push_entry_i,
  input  logic                      pop_i,
  input  logic                      recover_i,
  input  logic [ROB_W-1:0]          rec_rob_i,
  output cmpl_entry_t               head_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int AW = $clog2(DEPTH);

  cmpl_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  // One extra pointer bit tells full from empty after wrap.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    head_o = mem_q[rd_ptr_q[AW-1:0]];
    if (empty_o) head_o.valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (recover_i && mem_q[i].rob == rec_rob_i) mem_q[i].valid <= 1'b0;
      end
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/complete_arbiter.sv
// Complete stage: buffers ALU and load/store completions, grants one per cycle
// round-robin, and drives the registered completion bus.
module complete_arbiter #(
  parameter int DEPTH = 2,
  parameter int ROB_W = cpu_pkg::ROB_W,
  parameter int PR_W  = cpu_pkg::PR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob,
  input  logic [PR_W-1:0]  alu_p_rd,
  input  logic             alu_RegDest,
  input  logic [31:0]      alu_result,
  input  logic             alu_changeFlow,
  input  logic [31:0]      alu_jb_addr,
  input  logic             ls_valid,
  input  logic [ROB_W-1:0] ls_rob,
  input  logic [PR_W-1:0]  ls_p_rd,
  input  logic             ls_RegDest,
  input  logic [31:0]      ls_result,
  input  logic             recover,
  input  logic [ROB_W-1:0] rec_rob,
  output logic             alu_stall,
  output logic             ls_stall,
  output logic             complete,
  output logic [ROB_W-1:0] rob_num_compl,
  output logic [PR_W-1:0]  p_rd_compl,
  output logic             RegDest_compl,
  output logic [31:0]      result_compl,
  output logic             changeFlow_compl,
  output logic [31:0]      jb_addr_compl
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  cpu_pkg::cmpl_entry_t alu_in, ls_in, alu_head, ls_head, out_d, out_q;
  logic [CNT_W-1:0] alu_cnt, ls_cnt;
  logic alu_empty, ls_empty, alu_push, ls_push, alu_pop, ls_pop;
  logic alu_elig, ls_elig, gnt_alu, gnt_ls, last_ls_q;

  // Handshake: a source may present valid only while its stall is low; stall
  // is pure registered state, and an entry for the ROB slot being flushed is dropped.
  assign alu_push = alu_valid && !alu_stall && !(recover && alu_rob == rec_rob);
  assign ls_push  = ls_valid && !ls_stall && !(recover && ls_rob == rec_rob);

  always_comb begin
    alu_in = '0;
    alu_in.valid      = 1'b1;
    alu_in.rob        = alu_rob;
    alu_in.p_rd       = alu_p_rd;
    alu_in.RegDest    = alu_RegDest;
    alu_in.result     = alu_result;
    alu_in.changeFlow = alu_changeFlow;
    alu_in.jb_addr    = alu_jb_addr;
    ls_in = '0;
    ls_in.valid   = 1'b1;
    ls_in.rob     = ls_rob;
    ls_in.p_rd    = ls_p_rd;
    ls_in.RegDest = ls_RegDest;
    ls_in.result  = ls_result;
  end

  cmpl_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .push_i(alu_push), .push_entry_i(alu_in), .pop_i(alu_pop),
    .recover_i(recover), .rec_rob_i(rec_rob), .head_o(alu_head), .count_o(alu_cnt),
    .full_o(alu_stall), .empty_o(alu_empty)
  );

  cmpl_fifo #(.DEPTH(DEPTH)) u_ls_fifo (
    .clk(clk), .rst(rst), .push_i(ls_push), .push_entry_i(ls_in), .pop_i(ls_pop),
    .recover_i(recover), .rec_rob_i(rec_rob), .head_o(ls_head), .count_o(ls_cnt),
    .full_o(ls_stall), .empty_o(ls_empty)
  );

  always_comb begin
    alu_elig = alu_head.valid && !(recover && alu_head.rob == rec_rob);
    ls_elig  = ls_head.valid && !(recover && ls_head.rob == rec_rob);
    if (alu_elig && ls_elig) begin
      gnt_alu = last_ls_q;
      gnt_ls  = !last_ls_q;
    end else begin
      gnt_alu = alu_elig;
      gnt_ls  = ls_elig;
    end
    // Flushed heads leave without a grant so they never block the live ones behind.
    alu_pop = gnt_alu || (!alu_empty && !alu_head.valid);
    ls_pop  = gnt_ls || (!ls_empty && !ls_head.valid);
    out_d = '0;
    if (gnt_alu) out_d = alu_head;
    else if (gnt_ls) out_d = ls_head;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q     <= '0;
      last_ls_q <= 1'b1;
    end else begin
      out_q <= out_d;
      if (gnt_alu || gnt_ls) last_ls_q <= gnt_ls;
    end
  end

  assign complete         = out_q.valid;
  assign rob_num_compl    = out_q.rob;
  assign p_rd_compl       = out_q.p_rd;
  assign RegDest_compl    = out_q.valid & out_q.RegDest;
  assign result_compl     = out_q.result;
  assign changeFlow_compl = out_q.changeFlow;
  assign jb_addr_compl    = out_q.jb_addr;

  a_alu_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(alu_valid && alu_stall));
  a_ls_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(ls_valid && ls_stall));
  a_cnt_bound:       assert property (@(posedge clk) disable iff (!rst)
                                      alu_cnt <= CNT_W'(DEPTH) && ls_cnt <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_complete_arbiter.sv
// Bench for complete_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed completion order and values.
module tb_complete_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid, alu_RegDest, alu_changeFlow;
  logic [3:0]  alu_rob;
  logic [5:0]  alu_p_rd;
  logic [31:0] alu_result, alu_jb_addr;
  logic        ls_valid, ls_RegDest;
  logic [3:0]  ls_rob;
  logic [5:0]  ls_p_rd;
  logic [31:0] ls_result;
  logic        recover;
  logic [3:0]  rec_rob;
  logic        alu_stall, ls_stall, complete, RegDest_compl, changeFlow_compl;
  logic [3:0]  rob_num_compl;
  logic [5:0]  p_rd_compl;
  logic [31:0] result_compl, jb_addr_compl;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic [3:0] got_log[$];
  logic [3:0] exp_q[$];

  complete_arbiter #(.DEPTH(DEPTH), .ROB_W(4), .PR_W(6)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rob(alu_rob), .alu_p_rd(alu_p_rd), .alu_RegDest(alu_RegDest),
    .alu_result(alu_result), .alu_changeFlow(alu_changeFlow), .alu_jb_addr(alu_jb_addr),
    .ls_valid(ls_valid), .ls_rob(ls_rob), .ls_p_rd(ls_p_rd), .ls_RegDest(ls_RegDest),
    .ls_result(ls_result), .recover(recover), .rec_rob(rec_rob),
    .alu_stall(alu_stall), .ls_stall(ls_stall), .complete(complete),
    .rob_num_compl(rob_num_compl), .p_rd_compl(p_rd_compl), .RegDest_compl(RegDest_compl),
    .result_compl(result_compl), .changeFlow_compl(changeFlow_compl), .jb_addr_compl(jb_addr_compl)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  rob;
    logic [5:0]  prd;
    logic        rd;
    logic [31:0] res;
    logic        cf;
    logic [31:0] jb;
    bit          live;
  } m_ent_t;

  m_ent_t m_alu[$];
  m_ent_t m_ls[$];
  m_ent_t m_sel, m_new;
  bit m_last_ls, m_ea, m_el, m_ga, m_gl, m_fa, m_fl;
  logic [78:0] exp_vec;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_alu.delete();
      m_ls.delete();
      m_last_ls = 1'b1;
      exp_vec = '0;
    end else begin
      m_fa = (m_alu.size() == DEPTH);
      m_fl = (m_ls.size() == DEPTH);
      m_ea = (m_alu.size() > 0) && m_alu[0].live && !(recover && m_alu[0].rob == rec_rob);
      m_el = (m_ls.size() > 0) && m_ls[0].live && !(recover && m_ls[0].rob == rec_rob);
      if (m_ea && m_el) begin
        m_ga = m_last_ls;
        m_gl = !m_last_ls;
      end else begin
        m_ga = m_ea;
        m_gl = m_el;
      end
      m_sel = '{default: 0};
      if (m_ga) m_sel = m_alu[0];
      else if (m_gl) m_sel = m_ls[0];
      if (m_ga || (m_alu.size() > 0 && !m_alu[0].live)) void'(m_alu.pop_front());
      if (m_gl || (m_ls.size() > 0 && !m_ls[0].live)) void'(m_ls.pop_front());
      if (m_ga || m_gl) m_last_ls = m_gl;
      if (recover) begin
        foreach (m_alu[i]) if (m_alu[i].rob == rec_rob) m_alu[i].live = 0;
        foreach (m_ls[i]) if (m_ls[i].rob == rec_rob) m_ls[i].live = 0;
      end
      if (alu_valid && !m_fa && !(recover && alu_rob == rec_rob)) begin
        m_new = '{alu_rob, alu_p_rd, alu_RegDest, alu_result, alu_changeFlow, alu_jb_addr, 1};
        m_alu.push_back(m_new);
      end
      if (ls_valid && !m_fl && !(recover && ls_rob == rec_rob)) begin
        m_new = '{ls_rob, ls_p_rd, ls_RegDest, ls_result, 1'b0, 32'h0, 1};
        m_ls.push_back(m_new);
      end
      exp_vec = {(m_ga || m_gl), m_sel.rob, m_sel.prd, m_sel.rd, m_sel.res, m_sel.cf, m_sel.jb,
                 (m_alu.size() == DEPTH), (m_ls.size() == DEPTH)};
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [78:0] got_vec;
  always @(negedge clk) begin
    if (rst) begin
      got_vec = {complete, rob_num_compl, p_rd_compl, RegDest_compl, result_compl,
                 changeFlow_compl, jb_addr_compl, alu_stall, ls_stall};
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL model_cmp cycle=%0d got=%h exp=%h", cycle, got_vec, exp_vec);
      end
      if (complete === 1'b1) got_log.push_back(rob_num_compl);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, got_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_log.size(); i++)
      check($sformatf("%s_rob%0d", name, i), {28'h0, got_log[i]}, {28'h0, exp_q[i]});
    got_log.delete();
    exp_q.delete();
  endtask

  task automatic idle();
    alu_valid = 0; alu_rob = 0; alu_p_rd = 0; alu_RegDest = 0;
    alu_result = 0; alu_changeFlow = 0; alu_jb_addr = 0;
    ls_valid = 0; ls_rob = 0; ls_p_rd = 0; ls_RegDest = 0; ls_result = 0;
    recover = 0; rec_rob = 0;
  endtask

  task automatic drive_alu(input logic [3:0] rob, input logic [5:0] prd, input logic rd,
                           input logic [31:0] res, input logic cf, input logic [31:0] jb);
    alu_valid = 1; alu_rob = rob; alu_p_rd = prd; alu_RegDest = rd;
    alu_result = res; alu_changeFlow = cf; alu_jb_addr = jb;
  endtask

  task automatic drive_ls(input logic [3:0] rob, input logic [5:0] prd, input logic rd,
                          input logic [31:0] res);
    ls_valid = 1; ls_rob = rob; ls_p_rd = prd; ls_RegDest = rd; ls_result = res;
  endtask

  // Returns 1 ns after the falling edge, well away from the active edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  int na, nl;
  bit saw_stall;
  logic [3:0] alu_seen[$];
  logic [3:0] ls_seen[$];

  initial begin
    idle();
    #1 rst = 0;
    tick(2);
    check("rst_complete", complete, 0);
    check("rst_rob", rob_num_compl, 0);
    check("rst_result", result_compl, 0);
    check("rst_jb", jb_addr_compl, 0);
    check("rst_flags", {RegDest_compl, changeFlow_compl, p_rd_compl}, 0);
    check("rst_stalls", {alu_stall, ls_stall}, 0);
    rst = 1;
    tick(2);
    got_log.delete();

    // Tie from reset: ALU wins first, then strict alternation.
    drive_alu(4'd1, 6'd1, 1, 32'h11, 0, 0);
    drive_ls(4'd2, 6'd2, 1, 32'h22);
    tick();
    check("tie_e0_complete", complete, 0);
    drive_alu(4'd4, 6'd4, 1, 32'h44, 0, 0);
    drive_ls(4'd5, 6'd5, 1, 32'h55);
    tick();
    idle();
    check("tie_e1_rob", {complete, rob_num_compl}, {1'b1, 4'd1});
    tick();
    check("tie_e2_rob", {complete, rob_num_compl}, {1'b1, 4'd2});
    check("tie_e2_result", result_compl, 32'h22);
    tick();
    check("tie_e3_rob", {complete, rob_num_compl}, {1'b1, 4'd4});
    tick();
    check("tie_e4_rob", {complete, rob_num_compl}, {1'b1, 4'd5});
    tick();
    check("tie_e5_complete", complete, 0);
    exp_q = '{4'd1, 4'd2, 4'd4, 4'd5};
    check_log("tie_order");

    // ALU only: one-cycle latency, then idle.
    drive_alu(4'd3, 6'd12, 1, 32'hDEADBEEF, 0, 0);
    tick();
    idle();
    check("alu_e0_complete", complete, 0);
    tick();
    check("alu_e1_complete", complete, 1);
    check("alu_e1_rob", rob_num_compl, 3);
    check("alu_e1_prd", p_rd_compl, 12);
    check("alu_e1_regdest", RegDest_compl, 1);
    check("alu_e1_result", result_compl, 32'hDEADBEEF);
    tick();
    check("alu_e2_complete", complete, 0);
    check("alu_e2_result", result_compl, 0);

    // Branch redirect without register write.
    drive_alu(4'd2, 6'd0, 0, 32'h1234, 1, 32'h40);
    tick();
    idle();
    tick();
    check("br_complete", complete, 1);
    check("br_changeflow", changeFlow_compl, 1);
    check("br_jb_addr", jb_addr_compl, 32'h40);
    check("br_regdest", RegDest_compl, 0);
    tick();
    got_log.delete();

    // Both sources streaming; ALU must see its FIFO fill and nothing is lost.
    na = 0; nl = 0; saw_stall = 0;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (alu_stall) saw_stall = 1;
      if (na < 3 && !alu_stall) begin
        drive_alu(na[3:0], 6'd20 + na[5:0], 1, 32'hA000 + na, 0, 0);
        na++;
      end
      if (nl < 4 && !ls_stall) begin
        drive_ls(4'd8 + nl[3:0], 6'd30 + nl[5:0], 1, 32'hB000 + nl);
        nl++;
      end
      tick();
    end
    idle();
    check("full_alu_sent", na, 3);
    check("full_ls_sent", nl, 4);
    check("full_saw_alu_stall", {31'h0, saw_stall}, 1);
    alu_seen.delete();
    ls_seen.delete();
    foreach (got_log[i]) begin
      if (got_log[i] < 4'd8) alu_seen.push_back(got_log[i]);
      else ls_seen.push_back(got_log[i]);
    end
    got_log = alu_seen;
    exp_q = '{4'd0, 4'd1, 4'd2};
    check_log("full_alu");
    got_log = ls_seen;
    exp_q = '{4'd8, 4'd9, 4'd10, 4'd11};
    check_log("full_ls");

    // Recovery: rob 7 is flushed while queued behind rob 6.
    drive_alu(4'd14, 6'd14, 1, 32'hE, 0, 0);
    tick();
    idle();
    tick();
    drive_alu(4'd6, 6'd6, 1, 32'h66, 0, 0);
    drive_ls(4'd9, 6'd9, 1, 32'h99);
    tick();
    idle();
    drive_alu(4'd7, 6'd7, 1, 32'h77, 0, 0);
    tick();
    idle();
    check("rec_ls_wins", {complete, rob_num_compl}, {1'b1, 4'd9});
    check("rec_alu_full", alu_stall, 1);
    recover = 1;
    rec_rob = 4'd7;
    tick();
    idle();
    check("rec_rob6", {complete, rob_num_compl, result_compl}, {1'b1, 4'd6, 32'h66});
    tick();
    check("rec_no_rob7", complete, 0);
    check("rec_alu_empty", alu_stall, 0);
    tick(3);
    exp_q = '{4'd14, 4'd9, 4'd6};
    check_log("rec_order");

    // Reset mid-stream: outputs clear immediately, ALU wins the first tie after.
    drive_alu(4'd1, 6'd1, 1, 32'h1, 0, 0);
    drive_ls(4'd2, 6'd2, 1, 32'h2);
    tick();
    drive_alu(4'd3, 6'd3, 1, 32'h3, 0, 0);
    drive_ls(4'd4, 6'd4, 1, 32'h4);
    tick();
    idle();
    check("mid_pre_complete", {complete, rob_num_compl}, {1'b1, 4'd2});
    #1 rst = 0;
    #1;
    check("mid_async_complete", complete, 0);
    check("mid_async_data", {rob_num_compl, p_rd_compl, RegDest_compl}, 0);
    check("mid_async_result", result_compl, 0);
    check("mid_async_stalls", {alu_stall, ls_stall}, 0);
    tick(2);
    rst = 1;
    got_log.delete();
    tick(3);
    check("mid_quiet", got_log.size(), 0);
    drive_alu(4'd10, 6'd10, 1, 32'h10, 0, 0);
    drive_ls(4'd11, 6'd11, 1, 32'h11);
    tick();
    idle();
    tick(3);
    exp_q = '{4'd10, 4'd11};
    check_log("mid_tie");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
